// File: rtl/cve2_obi_mem_responder.sv
// OBI memory responder: grants core requests, carries them through a fixed-latency
// pipeline and commits reads/writes in grant order as each response is registered.
module cve2_obi_mem_responder #(
  parameter int unsigned MemSizeWords   = 1024,
  parameter logic [31:0] BaseAddr       = 32'h0000_0000,
  parameter int unsigned Latency        = 1,
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        req_i,
  output logic        gnt_o,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] wdata_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic [3:0]  outstanding_o
);

  localparam int unsigned AW      = (MemSizeWords > 1) ? $clog2(MemSizeWords) : 1;
  localparam logic [32:0] EndAddr = {1'b0, BaseAddr} + 33'(4 * MemSizeWords);

  typedef struct packed {
    logic          valid;
    logic          we;
    logic [AW-1:0] addr;
    logic [3:0]    be;
    logic [31:0]   wdata;
    logic          err;
  } entry_t;

  logic        transfer;
  logic        retire;
  logic [3:0]  outstanding_q;
  entry_t      cap;
  entry_t      head;
  logic [31:0] mem [MemSizeWords];
  logic        rvalid_q;
  logic        err_q;
  logic [31:0] rdata_q;

  // Handshake: a transfer happens in any cycle with req_i & gnt_o; the address
  // phase is sampled only then. Each transfer yields exactly one rvalid_o cycle.
  assign retire   = rvalid_q;
  assign gnt_o    = ~rst_i & req_i & ~stall_i &
                    ((outstanding_q < 4'(MaxOutstanding)) | retire);
  assign transfer = req_i & gnt_o;

  always_comb begin
    cap       = '0;
    cap.valid = transfer;
    cap.we    = we_i;
    cap.be    = be_i;
    cap.wdata = wdata_i;
    cap.err   = ({1'b0, addr_i} < {1'b0, BaseAddr}) | ({1'b0, addr_i} >= EndAddr);
    cap.addr  = AW'((addr_i - BaseAddr) >> 2);
  end

  // The registered response stage is the last of the Latency stages, so the
  // entry committed on an edge is the one feeding that register.
  generate
    if (Latency == 1) begin : g_direct
      assign head = cap;
    end else begin : g_pipe
      localparam int Depth = int'(Latency) - 1;
      entry_t pipe_q [Depth];

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          for (int i = 0; i < Depth; i++) pipe_q[i] <= '0;
        end else begin
          pipe_q[0] <= cap;
          for (int i = 1; i < Depth; i++) pipe_q[i] <= pipe_q[i-1];
        end
      end

      assign head = pipe_q[Depth-1];
    end
  endgenerate

  // Reset discards the head entry, so an in-flight write never lands.
  always_ff @(posedge clk_i) begin
    if (~rst_i & head.valid & head.we & ~head.err) begin
      for (int b = 0; b < 4; b++) begin
        if (head.be[b]) mem[head.addr][8*b +: 8] <= head.wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= head.valid;
      err_q    <= head.valid & head.err;
      rdata_q  <= (head.valid & ~head.we & ~head.err) ? mem[head.addr] : '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      outstanding_q <= '0;
    end else begin
      case ({transfer, retire})
        2'b10:   outstanding_q <= outstanding_q + 4'd1;
        2'b01:   outstanding_q <= outstanding_q - 4'd1;
        default: outstanding_q <= outstanding_q;
      endcase
    end
  end

  assign rvalid_o      = rvalid_q;
  assign rdata_o       = rdata_q;
  assign err_o         = err_q;
  assign outstanding_o = outstanding_q;

endmodule

// File: tb/tb_cve2_obi_mem_responder.sv
// Bench for cve2_obi_mem_responder: four instances with different latency/outstanding
// settings, each compared cycle by cycle against a queue-based transaction model.
module tb_cve2_obi_mem_responder;

  localparam int N = 4;
  localparam int          LAT  [N] = '{1, 3, 3, 4};
  localparam int          MO   [N] = '{1, 3, 2, 2};
  localparam logic [31:0] BASE [N] = '{32'h0, 32'h0, 32'h1000, 32'h0};
  localparam int          SIZE [N] = '{1024, 1024, 256, 1024};

  logic        clk = 1'b0;
  logic        rst    [N];
  logic        stall  [N];
  logic        req    [N];
  logic        gnt    [N];
  logic [31:0] addr   [N];
  logic        we     [N];
  logic [3:0]  be     [N];
  logic [31:0] wdata  [N];
  logic        rvalid [N];
  logic [31:0] rdata  [N];
  logic        err    [N];
  logic [3:0]  outs   [N];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct packed {
    logic [31:0] due;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } txn_t;

  txn_t        pend [N][$];
  logic [31:0] mmem [N][1024];
  logic [3:0]  mkn  [N][1024];

  logic        exp_gnt, exp_rvalid, exp_err, rdata_known;
  logic [31:0] exp_rdata;
  int          exp_out;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cve2_obi_mem_responder #(.MemSizeWords(SIZE[0]), .BaseAddr(BASE[0]), .Latency(LAT[0]), .MaxOutstanding(MO[0])) u_dut0 (
    .clk_i(clk), .rst_i(rst[0]), .stall_i(stall[0]), .req_i(req[0]), .gnt_o(gnt[0]), .addr_i(addr[0]),
    .we_i(we[0]), .be_i(be[0]), .wdata_i(wdata[0]), .rvalid_o(rvalid[0]), .rdata_o(rdata[0]),
    .err_o(err[0]), .outstanding_o(outs[0]));
  cve2_obi_mem_responder #(.MemSizeWords(SIZE[1]), .BaseAddr(BASE[1]), .Latency(LAT[1]), .MaxOutstanding(MO[1])) u_dut1 (
    .clk_i(clk), .rst_i(rst[1]), .stall_i(stall[1]), .req_i(req[1]), .gnt_o(gnt[1]), .addr_i(addr[1]),
    .we_i(we[1]), .be_i(be[1]), .wdata_i(wdata[1]), .rvalid_o(rvalid[1]), .rdata_o(rdata[1]),
    .err_o(err[1]), .outstanding_o(outs[1]));
  cve2_obi_mem_responder #(.MemSizeWords(SIZE[2]), .BaseAddr(BASE[2]), .Latency(LAT[2]), .MaxOutstanding(MO[2])) u_dut2 (
    .clk_i(clk), .rst_i(rst[2]), .stall_i(stall[2]), .req_i(req[2]), .gnt_o(gnt[2]), .addr_i(addr[2]),
    .we_i(we[2]), .be_i(be[2]), .wdata_i(wdata[2]), .rvalid_o(rvalid[2]), .rdata_o(rdata[2]),
    .err_o(err[2]), .outstanding_o(outs[2]));
  cve2_obi_mem_responder #(.MemSizeWords(SIZE[3]), .BaseAddr(BASE[3]), .Latency(LAT[3]), .MaxOutstanding(MO[3])) u_dut3 (
    .clk_i(clk), .rst_i(rst[3]), .stall_i(stall[3]), .req_i(req[3]), .gnt_o(gnt[3]), .addr_i(addr[3]),
    .we_i(we[3]), .be_i(be[3]), .wdata_i(wdata[3]), .rvalid_o(rvalid[3]), .rdata_o(rdata[3]),
    .err_o(err[3]), .outstanding_o(outs[3]));

  function automatic bit in_range(int k, logic [31:0] a);
    longint lo = longint'({32'b0, BASE[k]});
    longint av = longint'({32'b0, a});
    return (av >= lo) && (av < lo + 4 * SIZE[k]);
  endfunction

  // Drives one cycle on instance k and advances the reference model: responses
  // are due LAT cycles after a grant and memory is applied in grant order.
  task automatic step(int k, bit r, bit q, bit s, bit w, logic [31:0] a, logic [3:0] b, logic [31:0] d);
    txn_t t;
    int   idx;
    @(negedge clk);
    rst[k] = r; req[k] = q; stall[k] = s; we[k] = w; addr[k] = a; be[k] = b; wdata[k] = d;
    #1;
    exp_out = pend[k].size();
    exp_rvalid = 1'b0; exp_err = 1'b0; exp_rdata = '0; rdata_known = 1'b1;
    if (pend[k].size() > 0 && pend[k][0].due == 32'(cyc)) begin
      t = pend[k].pop_front();
      exp_rvalid = 1'b1;
      if (!in_range(k, t.addr)) begin
        exp_err = 1'b1;
      end else begin
        idx = int'((t.addr - BASE[k]) >> 2);
        if (t.we) begin
          for (int i = 0; i < 4; i++) begin
            if (t.be[i]) begin
              mmem[k][idx][8*i +: 8] = t.wdata[8*i +: 8];
              mkn[k][idx][i] = 1'b1;
            end
          end
        end else begin
          exp_rdata   = mmem[k][idx];
          rdata_known = &mkn[k][idx];
        end
      end
    end
    exp_gnt = !r && q && !s && (exp_out < MO[k] || exp_rvalid);
    if (exp_gnt) begin
      t.due = 32'(cyc + LAT[k]); t.we = w; t.addr = a; t.be = b; t.wdata = d;
      pend[k].push_back(t);
    end
    if (r) pend[k].delete();
  endtask

  task automatic test_reset();
    for (int k = 0; k < N; k++) begin
      step(k, 1, 1, 0, 1, 32'h4, 4'hF, 32'h1);
      n_checks++;
      if ({gnt[k], rvalid[k], err[k], outs[k], rdata[k]} !== 39'h0) begin
        n_fail++;
        $display("FAIL reset k=%0d gnt/rvalid/err/out/rdata got %b/%b/%b/%0d/%h want all 0",
                 k, gnt[k], rvalid[k], err[k], outs[k], rdata[k]);
      end
      step(k, 0, 0, 0, 0, 32'h0, 4'h0, 32'h0);
    end
  endtask

  task automatic test_write_read();
    bit q_t [4] = '{1, 0, 1, 0};
    bit w_t [4] = '{1, 0, 0, 0};
    for (int i = 0; i < 4; i++) begin
      step(0, 0, q_t[i], 0, w_t[i], 32'h10, 4'hF, 32'hDEADBEEF);
      n_checks++;
      if ({gnt[0], rvalid[0], err[0], outs[0]} !== {exp_gnt, exp_rvalid, exp_err, 4'(exp_out)}) begin
        n_fail++;
        $display("FAIL wr_ctrl i=%0d gnt/rvalid/err/out got %b/%b/%b/%0d want %b/%b/%b/%0d",
                 i, gnt[0], rvalid[0], err[0], outs[0], exp_gnt, exp_rvalid, exp_err, exp_out);
      end
      if (i == 3) begin
        n_checks++;
        if (rvalid[0] !== 1'b1 || rdata[0] !== 32'hDEADBEEF || err[0] !== 1'b0) begin
          n_fail++;
          $display("FAIL wr_data rvalid/rdata/err got %b/%h/%b want 1/deadbeef/0", rvalid[0], rdata[0], err[0]);
        end
      end
    end
  endtask

  task automatic test_byte_enables();
    bit          q_t [6] = '{1, 0, 1, 0, 1, 0};
    bit          w_t [6] = '{1, 0, 1, 0, 0, 0};
    logic [31:0] d_t [6] = '{32'h11223344, 0, 32'hAABBCCDD, 0, 0, 0};
    logic [3:0]  b_t [6] = '{4'hF, 4'hF, 4'b0101, 4'hF, 4'hF, 4'hF};
    for (int i = 0; i < 6; i++) begin
      step(0, 0, q_t[i], 0, w_t[i], 32'h20, b_t[i], d_t[i]);
      n_checks++;
      if ({gnt[0], rvalid[0], err[0], outs[0]} !== {exp_gnt, exp_rvalid, exp_err, 4'(exp_out)}) begin
        n_fail++;
        $display("FAIL be_ctrl i=%0d gnt/rvalid/err/out got %b/%b/%b/%0d want %b/%b/%b/%0d",
                 i, gnt[0], rvalid[0], err[0], outs[0], exp_gnt, exp_rvalid, exp_err, exp_out);
      end
      if (i == 5) begin
        n_checks++;
        if (rvalid[0] !== 1'b1 || rdata[0] !== 32'h11BB33DD) begin
          n_fail++;
          $display("FAIL be_data rvalid/rdata got %b/%h want 1/11bb33dd", rvalid[0], rdata[0]);
        end
      end
    end
  endtask

  task automatic test_out_of_range();
    bit          q_t [6] = '{1, 0, 1, 0, 1, 0};
    bit          w_t [6] = '{1, 0, 1, 0, 0, 0};
    logic [31:0] a_t [6] = '{32'h0, 32'h0, 32'h1000, 32'h0, 32'h0, 32'h0};
    logic [31:0] d_t [6] = '{32'h12345678, 0, 32'hFFFFFFFF, 0, 0, 0};
    for (int i = 0; i < 6; i++) begin
      step(0, 0, q_t[i], 0, w_t[i], a_t[i], 4'hF, d_t[i]);
      n_checks++;
      if ({gnt[0], rvalid[0], err[0], outs[0]} !== {exp_gnt, exp_rvalid, exp_err, 4'(exp_out)}) begin
        n_fail++;
        $display("FAIL oor_ctrl i=%0d gnt/rvalid/err/out got %b/%b/%b/%0d want %b/%b/%b/%0d",
                 i, gnt[0], rvalid[0], err[0], outs[0], exp_gnt, exp_rvalid, exp_err, exp_out);
      end
      if (i == 3) begin
        n_checks++;
        if (rvalid[0] !== 1'b1 || err[0] !== 1'b1 || rdata[0] !== 32'h0) begin
          n_fail++;
          $display("FAIL oor_err rvalid/err/rdata got %b/%b/%h want 1/1/00000000", rvalid[0], err[0], rdata[0]);
        end
      end
      if (i == 5) begin
        n_checks++;
        if (rvalid[0] !== 1'b1 || err[0] !== 1'b0 || rdata[0] !== 32'h12345678) begin
          n_fail++;
          $display("FAIL oor_keep rvalid/err/rdata got %b/%b/%h want 1/0/12345678", rvalid[0], err[0], rdata[0]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int run = 0;
    int peak = 0;
    for (int i = 0; i < 19; i++) begin
      bit q = (i < 6) || (i >= 9 && i < 15);
      step(1, 0, q, 0, i < 6, 32'h100 + 32'(4 * (i % 9)), 4'hF, $urandom);
      n_checks++;
      if ({gnt[1], rvalid[1], err[1], outs[1]} !== {exp_gnt, exp_rvalid, exp_err, 4'(exp_out)}) begin
        n_fail++;
        $display("FAIL b2b_ctrl i=%0d gnt/rvalid/err/out got %b/%b/%b/%0d want %b/%b/%b/%0d",
                 i, gnt[1], rvalid[1], err[1], outs[1], exp_gnt, exp_rvalid, exp_err, exp_out);
      end
      if (rdata_known) begin
        n_checks++;
        if (rdata[1] !== exp_rdata) begin
          n_fail++;
          $display("FAIL b2b_data i=%0d rdata got %h want %h", i, rdata[1], exp_rdata);
        end
      end
      if (i >= 9 && i < 15 && gnt[1] === 1'b1) run++;
      if (int'(outs[1]) > peak) peak = int'(outs[1]);
    end
    n_checks++;
    if (run != 6 || peak != 3) begin
      n_fail++;
      $display("FAIL b2b_rate read grants/peak got %0d/%0d want 6/3", run, peak);
    end
  endtask

  task automatic test_throttle();
    logic g [16];
    int   peak = 0;
    for (int i = 0; i < 16; i++) begin
      step(2, 0, i < 12, 0, 1'b0, BASE[2] + 32'(4 * i), 4'hF, 32'h0);
      n_checks++;
      if ({gnt[2], rvalid[2], err[2], outs[2]} !== {exp_gnt, exp_rvalid, exp_err, 4'(exp_out)}) begin
        n_fail++;
        $display("FAIL thr_ctrl i=%0d gnt/rvalid/err/out got %b/%b/%b/%0d want %b/%b/%b/%0d",
                 i, gnt[2], rvalid[2], err[2], outs[2], exp_gnt, exp_rvalid, exp_err, exp_out);
      end
      g[i] = gnt[2];
      if (int'(outs[2]) > peak) peak = int'(outs[2]);
    end
    n_checks++;
    if ({g[0], g[1], g[2], g[3]} !== 4'b1101 || peak != 2) begin
      n_fail++;
      $display("FAIL thr_pattern first grants/peak got %b%b%b%b/%0d want 1101/2", g[0], g[1], g[2], g[3], peak);
    end
  endtask

  task automatic test_reset_midflight();
    int n_rv = 0;
    for (int i = 0; i < 19; i++) begin
      bit q = (i == 0) || (i == 5) || (i == 14);
      step(3, i == 7, q, 0, i < 6, 32'h40, 4'hF, (i == 0) ? 32'hCAFEF00D : 32'h0BADC0DE);
      n_checks++;
      if ({gnt[3], rvalid[3], err[3], outs[3]} !== {exp_gnt, exp_rvalid, exp_err, 4'(exp_out)}) begin
        n_fail++;
        $display("FAIL rst_ctrl i=%0d gnt/rvalid/err/out got %b/%b/%b/%0d want %b/%b/%b/%0d",
                 i, gnt[3], rvalid[3], err[3], outs[3], exp_gnt, exp_rvalid, exp_err, exp_out);
      end
      if (i >= 6 && i <= 13 && rvalid[3] === 1'b1) n_rv++;
      if (i == 8) begin
        n_checks++;
        if (outs[3] !== 4'd0) begin
          n_fail++;
          $display("FAIL rst_outstanding got %0d want 0", outs[3]);
        end
      end
      if (i == 18) begin
        n_checks++;
        if (rvalid[3] !== 1'b1 || rdata[3] !== 32'hCAFEF00D) begin
          n_fail++;
          $display("FAIL rst_keep rvalid/rdata got %b/%h want 1/cafef00d", rvalid[3], rdata[3]);
        end
      end
    end
    n_checks++;
    if (n_rv != 0) begin
      n_fail++;
      $display("FAIL rst_drop responses after reset got %0d want 0", n_rv);
    end
  endtask

  task automatic test_random(int k);
    logic [31:0] a;
    int          sel;
    for (int i = 0; i < 400 + LAT[k] + 1; i++) begin
      bit active = (i < 400);
      sel = $urandom_range(0, 9);
      if (sel == 0 && BASE[k] != 0) a = BASE[k] - 32'(4 * $urandom_range(1, 4));
      else if (sel <= 1)            a = BASE[k] + 32'(4 * SIZE[k]) + 32'(4 * $urandom_range(0, 3));
      else if (sel == 2)            a = BASE[k] + 32'(4 * (SIZE[k] - 1));
      else                          a = BASE[k] + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
      step(k, active && ($urandom_range(0, 63) == 0), active && ($urandom_range(0, 3) != 0),
           $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, a, 4'($urandom_range(0, 15)), $urandom);
      n_checks++;
      if ({gnt[k], rvalid[k], err[k], outs[k]} !== {exp_gnt, exp_rvalid, exp_err, 4'(exp_out)}) begin
        n_fail++;
        $display("FAIL rnd_ctrl k=%0d i=%0d gnt/rvalid/err/out got %b/%b/%b/%0d want %b/%b/%b/%0d",
                 k, i, gnt[k], rvalid[k], err[k], outs[k], exp_gnt, exp_rvalid, exp_err, exp_out);
      end
      if (rdata_known) begin
        n_checks++;
        if (rdata[k] !== exp_rdata) begin
          n_fail++;
          $display("FAIL rnd_data k=%0d i=%0d rdata got %h want %h", k, i, rdata[k], exp_rdata);
        end
      end
    end
  endtask

  initial begin
    for (int k = 0; k < N; k++) begin
      rst[k] = 1'b1; req[k] = 1'b0; stall[k] = 1'b0; we[k] = 1'b0;
      addr[k] = '0; be[k] = '0; wdata[k] = '0;
      for (int w = 0; w < 1024; w++) mkn[k][w] = 4'h0;
    end
    repeat (2) @(negedge clk);
    test_reset();
    test_write_read();
    test_byte_enables();
    test_out_of_range();
    test_back_to_back();
    test_throttle();
    test_reset_midflight();
    test_random(2);
    test_random(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cve2_obi_mem_responder.md
Name: cve2_obi_mem_responder

Overview:
- Synthesizable OBI responder: the memory-side end of the core's instruction/data bus (core is initiator).
- Grants requests, queues them through a fixed-latency response pipeline and returns rvalid/rdata/err in request order.
- Backs simulation and FPGA test tops; one instance per bus (instr, data).

Parameters:
- MemSizeWords, 1024: number of 32-bit words in the backing array.
- BaseAddr, 32'h0000_0000: byte address of word 0; must be 4-byte aligned.
- Latency, 1: cycles from grant to rvalid; legal range 1..8.
- MaxOutstanding, 2: maximum granted-but-unanswered requests; legal range 1..Latency.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  synchronous reset, active-high.
- stall_i  in  1  bench/platform backpressure; forces gnt_o low.
- req_i  in  1  OBI request.
- gnt_o  out  1  OBI grant; combinational.
- addr_i  in  32  byte address; bits [1:0] ignored.
- we_i  in  1  1 = write, 0 = read.
- be_i  in  4  byte enables; applied to writes only.
- wdata_i  in  32  write data.
- rvalid_o  out  1  response valid, exactly one cycle per granted request.
- rdata_o  out  32  read data; 0 for writes and errors.
- err_o  out  1  response error; qualified by rvalid_o.
- outstanding_o  out  4  current count of in-flight requests.

Behaviour:
- Reset: rvalid_o=0, rdata_o=0, err_o=0, outstanding_o=0, all pipeline stages invalid. gnt_o=0 while rst_i=1. Memory contents are not reset.
- Grant rule: gnt_o = ~rst_i & req_i & ~stall_i & (outstanding_q < MaxOutstanding | retire). retire = the last pipeline stage holds a valid entry this cycle.
- Handshake: a transfer occurs when req_i & gnt_o. The address phase is captured only in that cycle; there is no skid buffer.
- Pipeline: Latency-deep shift line of {valid, we, word_addr, be, wdata, err}. It advances every cycle; nothing stalls it. A transfer in cycle T produces rvalid_o=1 in cycle T+Latency.
- Error decode at capture: err=1 when addr_i < BaseAddr or addr_i >= BaseAddr + 4*MemSizeWords.
- word_addr = (addr_i - BaseAddr) >> 2, with width clog2(MemSizeWords).
- Commit point: memory is read or written in the response cycle, when the entry leaves the last stage. Accesses therefore complete strictly in grant order, so a read granted after a write to the same word returns the new data.
- Write with err=0: each byte lane i with be_i[i]=1 updated from wdata. Response rdata_o=0, err_o=0.
- Read with err=0: rdata_o = full word; be ignored. err_o=0.
- Any err=1 entry: no memory update, rdata_o=0, err_o=1.
- Response outputs are registered. When no response is presented: rvalid_o=0 and rdata_o/err_o are held at 0.
- Outstanding counter:
  - +1 on transfer, -1 on response.
  - Transfer and response in the same cycle leave it unchanged.
  - Never exceeds MaxOutstanding, never underflows.
- Back-to-back: with MaxOutstanding=Latency, one grant per cycle is sustained indefinitely.
- Reset asserted mid-operation: all in-flight entries are discarded with no writes committed. rvalid_o=0 from the first cycle after rst_i is sampled high.
- stall_i and req_i may change every cycle. A dropped req_i without a grant has no effect.

Test Plan:
- Latency=1, MaxOutstanding=1: write 0xDEADBEEF to 0x10, be=4'hF, then read 0x10. Required: grants in cycles T and T+2, rvalid at T+1 and T+3, read rdata_o=0xDEADBEEF, err_o=0 on both.
- Byte enables: word 0x20 holds 0x11223344; write 0xAABBCCDD with be=4'b0101, then read 0x20. Required: rdata_o=0x11BB33DD.
- Latency=3, MaxOutstanding=3: req_i held high for 6 reads. Required:
  - gnt_o high for 6 consecutive cycles.
  - rvalid_o high 3 cycles after each grant.
  - outstanding_o peaks at 3.
- Latency=3, MaxOutstanding=2: req_i held high. Required:
  - gnt_o high for 2 cycles, low for 1, then high 1 cycle in every ... until the pattern settles.
  - outstanding_o never reaches 3.
- Out of range: MemSizeWords=1024, BaseAddr=0, write to 0x1000. Required: rvalid_o with err_o=1, rdata_o=0; a subsequent read of 0x0 is unchanged.
- Reset mid-flight: Latency=4; grant a write to 0x40, assert rst_i 2 cycles later for 1 cycle. Required: no rvalid_o for that write, outstanding_o=0 after reset, and a later read of 0x40 returns the pre-write value.
